// File: rtl/pg_box_anim.sv
// Animated rectangle pattern generator: static, bounce, scroll-with-wrap or blink,
// position updated once per frame, registered colour outputs.
module pg_box_anim #(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int BOX_W        = 100,
    parameter int BOX_H        = 100,
    parameter int X0           = 270,
    parameter int Y0           = 120,
    parameter int STEP         = 2,
    parameter int BLINK_FRAMES = 30,
    parameter int COLOR_W      = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [9:0]         hPixel,
    input  logic [9:0]         vLine,
    input  logic               frameStart,
    input  logic [1:0]         mode,
    input  logic [2:0]         SW,
    output logic [COLOR_W-1:0] RED,
    output logic [COLOR_W-1:0] GRN,
    output logic [COLOR_W-1:0] BLU,
    output logic [9:0]         boxX,
    output logic [9:0]         boxY
);

    typedef enum logic [1:0] {
        M_STATIC = 2'b00,
        M_BOUNCE = 2'b01,
        M_SCROLL = 2'b10,
        M_BLINK  = 2'b11
    } mode_t;

    localparam logic [10:0] HA   = 11'(H_ACTIVE);
    localparam logic [10:0] VA   = 11'(V_ACTIVE);
    localparam logic [10:0] BW   = 11'(BOX_W);
    localparam logic [10:0] BH   = 11'(BOX_H);
    localparam logic [10:0] ST   = 11'(STEP);
    localparam logic [10:0] XMAX = 11'(H_ACTIVE - BOX_W);
    localparam logic [10:0] YMAX = 11'(V_ACTIVE - BOX_H);
    localparam logic [9:0]  RX   = 10'(X0);
    localparam logic [9:0]  RY   = 10'(Y0);
    localparam logic [15:0] BLAST = 16'(BLINK_FRAMES - 1);

    mode_t       curMode;
    logic        dirX;
    logic        dirY;
    logic [15:0] blinkCnt;
    logic        visible;

    logic [10:0] x11, y11, h11, v11;
    logic [10:0] xStep, yStep, xEnd, yEnd;
    logic [10:0] nx, ny;
    logic        ndx, ndy;
    logic        inX, inY, active, hit;

    assign x11   = {1'b0, boxX};
    assign y11   = {1'b0, boxY};
    assign h11   = {1'b0, hPixel};
    assign v11   = {1'b0, vLine};
    assign xStep = x11 + ST;
    assign yStep = y11 + ST;
    assign xEnd  = x11 + BW;
    assign yEnd  = y11 + BH;

    // Next position for the mode being sampled this frameStart
    always_comb begin
        nx  = x11;
        ny  = y11;
        ndx = dirX;
        ndy = dirY;
        unique case (mode_t'(mode))
            M_STATIC: begin
                nx = {1'b0, RX};
                ny = {1'b0, RY};
            end
            M_BOUNCE: begin
                if (dirX) begin
                    if (x11 < ST) begin
                        nx  = '0;
                        ndx = 1'b0;
                    end else begin
                        nx = x11 - ST;
                    end
                end else if (xStep > XMAX) begin
                    nx  = XMAX;
                    ndx = 1'b1;
                end else begin
                    nx = xStep;
                end
                if (dirY) begin
                    if (y11 < ST) begin
                        ny  = '0;
                        ndy = 1'b0;
                    end else begin
                        ny = y11 - ST;
                    end
                end else if (yStep > YMAX) begin
                    ny  = YMAX;
                    ndy = 1'b1;
                end else begin
                    ny = yStep;
                end
            end
            M_SCROLL: begin
                if (xStep >= HA) nx = xStep - HA;
                else             nx = xStep;
            end
            M_BLINK: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            curMode  <= M_STATIC;
            boxX     <= RX;
            boxY     <= RY;
            dirX     <= 1'b0;
            dirY     <= 1'b0;
            blinkCnt <= '0;
            visible  <= 1'b1;
        end else if (frameStart) begin
            curMode <= mode_t'(mode);
            boxX    <= nx[9:0];
            boxY    <= ny[9:0];
            dirX    <= ndx;
            dirY    <= ndy;
            if (mode_t'(mode) == M_BLINK) begin
                if (blinkCnt == BLAST) begin
                    blinkCnt <= '0;
                    visible  <= ~visible;
                end else begin
                    blinkCnt <= blinkCnt + 16'd1;
                end
            end else begin
                blinkCnt <= '0;
                visible  <= 1'b1;
            end
        end
    end

    // Scroll mode lets the right part of the box wrap to column 0
    always_comb begin
        inX = (h11 >= x11) && (h11 < xEnd);
        if (curMode == M_SCROLL && xEnd > HA && h11 < xEnd - HA)
            inX = 1'b1;
    end

    assign inY    = (v11 >= y11) && (v11 < yEnd);
    assign active = (h11 < HA) && (v11 < VA);
    assign hit    = inX & inY & active & visible;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RED <= '0;
            GRN <= '0;
            BLU <= '0;
        end else begin
            RED <= {COLOR_W{hit & SW[2]}};
            GRN <= {COLOR_W{hit & SW[1]}};
            BLU <= {COLOR_W{hit & SW[0]}};
        end
    end

endmodule
